// File: rtl/simpsons_stimulus.sv
// Gate-sensor pattern generator: plays Bart/Homer walk waveforms on the G bus
// and tracks the expected occupancy for comparison against simpsons_sensor.
module simpsons_stimulus #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [1:0]         o_g,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_exp_level
);

    // state | meaning
    // IDLE  | waiting for a command, G=00
    // PH1-4 | playing phase n of the latched pattern
    // CLR   | one-cycle model clear
    typedef enum logic [2:0] {
        IDLE, PH1, PH2, PH3, PH4, CLR
    } state_t;

    localparam logic [1:0] CMD_BART    = 2'd0;
    localparam logic [1:0] CMD_CLEAR   = 2'd3;
    localparam logic [1:0] LVL_NONE    = 2'd0;
    localparam logic [1:0] LVL_BART    = 2'd1;
    localparam logic [1:0] LVL_HOMER   = 2'd2;

    state_t             r_state;
    logic [1:0]         r_cmd;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_g;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_exp;

    state_t             w_next;
    logic               w_last;

    function automatic logic [1:0] phase_g(input logic [1:0] cmd, input state_t st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            PH1:     g = (cmd == CMD_BART) ? 2'b01 : 2'b10;
            PH2:     g = (cmd == 2'd2) ? 2'b11 : 2'b00;
            PH3:     g = 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_comb begin
        w_next = IDLE;
        case (r_state)
            PH1:     w_next = PH2;
            PH2:     w_next = PH3;
            PH3:     w_next = PH4;
            default: w_next = IDLE;
        endcase
    end

    // Bart is a two-phase walk; the Homer walks run all four phases.
    assign w_last = (r_state == PH4) || ((r_state == PH2) && (r_cmd == CMD_BART));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cmd   <= 2'd0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_g     <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_exp   <= LVL_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd   <= i_cmd;
                        r_dwell <= i_dwell;
                        r_cnt   <= i_dwell;
                        r_busy  <= 1'b1;
                        if (i_cmd == CMD_CLEAR) begin
                            r_state <= CLR;
                            r_g     <= 2'b00;
                        end else begin
                            r_state <= PH1;
                            r_g     <= phase_g(i_cmd, PH1);
                        end
                    end
                end
                CLR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_exp   <= LVL_NONE;
                end
                default: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_g     <= 2'b00;
                        r_exp   <= r_exp ^ ((r_cmd == CMD_BART) ? LVL_BART : LVL_HOMER);
                    end else begin
                        r_state <= w_next;
                        r_g     <= phase_g(r_cmd, w_next);
                        r_cnt   <= r_dwell;
                    end
                end
            endcase
        end
    end

    assign o_cmd_ready = ~r_busy;
    assign o_g         = r_g;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_exp_level = r_exp;

endmodule

// File: doc/simpsons_stimulus.md
Name: simpsons_stimulus

Overview:
Gate-sensor pattern generator that drives the two-bit G bus consumed by simpsons_sensor. It accepts walk commands (Bart pass, Homer pass with gap, Homer pass with overlap) over a valid/ready handshake. It plays out the matching sensor waveform with a programmable dwell per phase. It keeps a reference occupancy model (EXP_LEVEL) that the bench compares against the sensor's LEVEL output.

Parameters:
DWELL_W, 8, width of the per-command dwell field and the phase counter
LVL_NONE/LVL_BART/LVL_HOMER/LVL_BOTH, 0/1/2/3, occupancy encodings (same values as the sensor's LEVEL)

Ports:
CLK  in  1  system clock; rising edge only
RESET  in  1  asynchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  block can accept a command; equals ~BUSY
CMD  in  2  0=Bart pass, 1=Homer pass (gap), 2=Homer pass (overlap), 3=clear model
DWELL  in  DWELL_W  phase hold minus one; sampled only on accept
G  out  2  sensor bus to simpsons_sensor; G[0]=low beam, G[1]=high beam; registered
BUSY  out  1  pattern in progress
DONE  out  1  one-cycle pulse at pattern completion
EXP_LEVEL  out  2  model occupancy, bit0=Bart inside, bit1=Homer inside

Behaviour:
- Reset is asynchronous and active-high. CLK is the only clock, and all state changes on its rising edge.
- Reset values: G=00, BUSY=0, CMD_READY=1, DONE=0, EXP_LEVEL=00, state IDLE, phase counter 0, latched dwell 0.
- Accept: CMD_VALID & CMD_READY at a rising edge. CMD and DWELL are latched at that edge. CMD_VALID while BUSY is ignored, and no command is queued.
- States: IDLE, PH1, PH2, PH3, PH4, CLR.
- Phase sequences for G, each phase held DWELL+1 cycles:
  - CMD0 (Bart): PH1=01, PH2=00. Total 2 phases.
  - CMD1 (Homer gap): PH1=10, PH2=00, PH3=01, PH4=00.
  - CMD2 (Homer overlap): PH1=10, PH2=11, PH3=01, PH4=00.
  - CMD3 (clear): goes to CLR for 1 cycle. G stays 00, EXP_LEVEL becomes 00, then DONE.
- Timing: G takes its PH1 value on the accept edge and BUSY=1 from that edge. The phase counter loads DWELL and decrements to 0. On 0, the next phase loads. DWELL=0 gives a 1-cycle phase; DWELL=255 gives 256 cycles.
- Completion: on the edge that ends the last phase:
  - DONE=1 for exactly one cycle.
  - BUSY drops.
  - G stays 00.
  - EXP_LEVEL updates in the same edge: CMD0 toggles bit0, CMD1/CMD2 toggle bit1.
- Busy duration: BUSY is high for phases*(DWELL+1) cycles (Bart 2*(D+1), Homer 4*(D+1), clear 1).
- Back-to-back commands: a new command may be accepted in the cycle after DONE (READY rises with DONE). G is 00 for at least that one cycle between patterns.
- Pattern constraints:
  - G=11 is emitted only in CMD2 PH2.
  - A Bart pattern never drives G[1].
  - Every pattern ends with G=00.
- Direction: enter versus leave is not encoded in the command. The sensor infers it from current occupancy, and EXP_LEVEL toggling mirrors that.
- Reset mid-pattern: G returns to 00 immediately (asynchronously), with no DONE and EXP_LEVEL=00. The bench must also reset simpsons_sensor to keep the models aligned.
- No combinational path from CMD_VALID to any output except through registers; CMD_READY is a direct function of BUSY.

Test Plan:
- Reset, then CMD0 with DWELL=2 → G=01 for 3 cycles, then 00 for 3 cycles. DONE pulses at cycle 6 and EXP_LEVEL=01. Sensor LEVEL=1.
- From EXP_LEVEL=01: CMD2 with DWELL=0 → G goes 10,11,01,00, one cycle each. DONE at cycle 4 and EXP_LEVEL=11. Sensor LEVEL=3.
- From EXP_LEVEL=11: CMD1 with DWELL=1 → G goes 10,10,00,00,01,01,00,00. EXP_LEVEL=01, then CMD0 → EXP_LEVEL=00. Sensor LEVEL tracks 1 then 0.
- Hold CMD_VALID high with CMD0 while BUSY from a CMD1 → CMD_READY=0 throughout and the second command is not taken until the cycle after DONE. Only two DONE pulses in total.
- Assert RESET during CMD2 PH2 (G=11) → G=00, BUSY=0, EXP_LEVEL=00 immediately, and no DONE.
- CMD3 when EXP_LEVEL=10 → BUSY for 1 cycle, G stays 00, DONE pulses, EXP_LEVEL=00.
